generation_scheduler: RTL and testbench
=======================================

// Module: generation_scheduler
// PURPOSE
//  Sequences life_game generation updates; replaces the free-running divider/mux clock.
//  Single clock domain: derives the step period, handles run/pause, single-step and clear,
//  and issues req/done handshakes to the life_game datapath. Holds off steps during pointer edits.
// PARAMETERS
//  TICK_DIVIDER  12_500_000  clock cycles in base period (125 ms @ 100 MHz); >= 2
//  COUNT_WIDTH   16          width of generation_count
// PORTS
//  clock             in   1   system clock, all logic on posedge
//  reset_n           in   1   asynchronous active-low reset
//  run               in   1   level (debounced switch): 1 = auto-run, 0 = paused
//  speed             in   2   period = TICK_DIVIDER << speed (0:125ms 1:250ms 2:500ms 3:1s)
//  step              in   1   level (debounced button); rising edge = single-step request
//  clear             in   1   level (debounced button); rising edge = clear board request
//  edit_hold         in   1   1 = pointer edit in progress, no new request may be issued
//  step_req          out  1   generation step request to life_game
//  step_done         in   1   1-cycle pulse from life_game: step finished
//  clear_req         out  1   board clear request to life_game
//  clear_done        in   1   1-cycle pulse from life_game: clear finished
//  busy              out  1   1 while in ISSUE_STEP/ISSUE_CLEAR
//  generation_count  out  COUNT_WIDTH  completed generations since reset/clear, wraps
//  overrun_count     out  8   ticks lost while busy (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state=IDLE; step_req, clear_req, busy, pending=0; generation_count=0;
//   overrun_count=0; tick counter=0; step/clear edge-detect history=0.
//  Edge detect: step_edge = step & ~step_q, clear_edge likewise; registered history.
//  Tick counter: runs only while run=1; counts 0..(TICK_DIVIDER<<speed_l)-1; tick = 1 cycle
//   at terminal count, then reloads 0. speed_l = speed sampled at reload and on run 0->1
//   (mid-period speed changes apply next period). run=0 forces counter=0, no ticks.
//  pending: 1-deep step latch. Set on tick, or on step_edge when run=0. Cleared when
//   step_req is raised, or on clear_edge. Set on tick while pending=1 = overrun.
//  States:
//   IDLE: if clear_latched & ~edit_hold -> ISSUE_CLEAR (clear_req=1 next cycle);
//    else if pending & ~edit_hold -> ISSUE_STEP (step_req=1 next cycle, pending<=0).
//    Clear has priority over step in the same cycle.
//   ISSUE_STEP: step_req held high until step_done seen; on step_done: step_req<=0,
//    generation_count<=count+1 (wraps max->0), -> IDLE. Latency edge->req: 2 cycles.
//   ISSUE_CLEAR: clear_req held high until clear_done; then clear_req<=0,
//    generation_count<=0, pending<=0, -> IDLE.
//  clear_edge in any state sets clear_latched (cleared on entry to ISSUE_CLEAR);
//   a clear never aborts an in-flight step. step_edge while run=1 ignored.
//  step_done/clear_done outside the matching ISSUE state: ignored, no count change.
//  edit_hold never drops an active request; it only blocks IDLE -> ISSUE_*.
//  Back-to-back: IDLE with pending re-enters ISSUE_STEP the cycle after done.
//  reset_n low mid-handshake: outputs drop immediately (async), request is abandoned.
// CONFIGURATION
//  OVERRUN_COUNTER_EN defined: overrun_count increments (saturates at 255) on every
//   tick arriving while pending=1; cleared by reset and clear completion.
//  Not defined: overrun_count tied to 8'd0, no counter logic; lost ticks silently dropped.
// TESTING (TICK_DIVIDER=4)
//  1 run=1, speed=0, done 1 cycle after req -> step_req every 4 cycles; count 0,1,2,3.
//  2 run=1, speed 0->3 mid-period -> current period stays 4, following periods 32 cycles.
//  3 run=0, step pulse held 10 cycles -> exactly one step_req; count +1; no ticks.
//  4 run=1, step_done withheld 20 cycles -> one pending step issued after done;
//    with OVERRUN_COUNTER_EN overrun_count=4, without =0.
//  5 clear_edge during ISSUE_STEP, count=5 -> step completes (6), then clear_req; count=0.
//  6 edit_hold=1 across tick -> no req; release -> step_req next cycle; reset_n low
//    mid-req -> step_req=0 same cycle, count=0.

Source files
------------

// File: rtl/generation_scheduler.sv
// Generation step/clear sequencer for life_game: tick divider, run/pause, single-step, clear handshakes.
// Optional OVERRUN_COUNTER_EN: counts ticks lost while a step is already pending.
module generation_scheduler #(
  parameter int unsigned TICK_DIVIDER = 12_500_000,
  parameter int unsigned COUNT_WIDTH  = 16
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   run,
  input  logic [1:0]             speed,
  input  logic                   step,
  input  logic                   clear,
  input  logic                   edit_hold,
  output logic                   step_req,
  input  logic                   step_done,
  output logic                   clear_req,
  input  logic                   clear_done,
  output logic                   busy,
  output logic [COUNT_WIDTH-1:0] generation_count,
  output logic [7:0]             overrun_count
);

  localparam int unsigned PER_W = $clog2(TICK_DIVIDER * 8);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    ISSUE_STEP  = 2'd1,
    ISSUE_CLEAR = 2'd2
  } state_t;

  state_t           state;
  logic [PER_W-1:0] tick_cnt;
  logic [1:0]       speed_l;
  logic             step_q;
  logic             clear_q;
  logic             pending;
  logic             clear_latched;

  logic [1:0]       speed_sel;
  logic [PER_W-1:0] term_cnt;
  logic             tick;
  logic             step_edge;
  logic             clear_edge;
  logic             issue_step;
  logic             enter_clear;
  logic             clear_finish;

  // A period starts whenever the counter sits at zero, so speed is taken fresh there.
  assign speed_sel    = (tick_cnt == '0) ? speed : speed_l;
  assign term_cnt     = PER_W'((TICK_DIVIDER << speed_sel) - 32'd1);
  assign tick         = run & (tick_cnt == term_cnt);
  assign step_edge    = step & ~step_q;
  assign clear_edge   = clear & ~clear_q;
  assign enter_clear  = (state == IDLE) & clear_latched & ~edit_hold;
  assign issue_step   = (state == IDLE) & ~clear_latched & pending & ~edit_hold;
  assign clear_finish = (state == ISSUE_CLEAR) & clear_done;

  // Step period counter and input edge history
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt <= '0;
      speed_l  <= 2'd0;
      step_q   <= 1'b0;
      clear_q  <= 1'b0;
    end else begin
      step_q  <= step;
      clear_q <= clear;
      if (tick_cnt == '0) speed_l <= speed;
      if (!run || tick) tick_cnt <= '0;
      else              tick_cnt <= tick_cnt + PER_W'(1);
    end
  end

  // Request latches; a tick landing while a step is already pending is lost
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pending       <= 1'b0;
      clear_latched <= 1'b0;
    end else begin
      if (clear_edge || clear_finish || issue_step) pending <= 1'b0;
      else if (tick || (step_edge && !run))         pending <= 1'b1;
      clear_latched <= clear_edge | (clear_latched & ~enter_clear);
    end
  end

  // Handshake FSM; clear wins over a pending step when both are ready
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      step_req         <= 1'b0;
      clear_req        <= 1'b0;
      busy             <= 1'b0;
      generation_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (enter_clear) begin
            state     <= ISSUE_CLEAR;
            clear_req <= 1'b1;
            busy      <= 1'b1;
          end else if (issue_step) begin
            state    <= ISSUE_STEP;
            step_req <= 1'b1;
            busy     <= 1'b1;
          end
        end
        ISSUE_STEP: begin
          if (step_done) begin
            state            <= IDLE;
            step_req         <= 1'b0;
            busy             <= 1'b0;
            generation_count <= generation_count + COUNT_WIDTH'(1);
          end
        end
        ISSUE_CLEAR: begin
          if (clear_done) begin
            state            <= IDLE;
            clear_req        <= 1'b0;
            busy             <= 1'b0;
            generation_count <= '0;
          end
        end
        default: begin
          state     <= IDLE;
          step_req  <= 1'b0;
          clear_req <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

`ifdef OVERRUN_COUNTER_EN
  // Saturating count of lost ticks
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      overrun_count <= 8'd0;
    end else if (clear_finish) begin
      overrun_count <= 8'd0;
    end else if (tick && pending && (overrun_count != 8'hFF)) begin
      overrun_count <= overrun_count + 8'd1;
    end
  end
`else
  assign overrun_count = 8'd0;
`endif

endmodule

// File: tb/tb_generation_scheduler.sv
// Self-checking bench for generation_scheduler: directed scenarios then randomized traffic,
// compared every cycle against a behavioural model of the scheduling rules.
module tb_generation_scheduler;

  localparam int unsigned TD = 4;
  localparam int unsigned CW = 4;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          run;
  logic [1:0]    speed;
  logic          step;
  logic          clear;
  logic          edit_hold;
  logic          step_req;
  logic          step_done;
  logic          clear_req;
  logic          clear_done;
  logic          busy;
  logic [CW-1:0] generation_count;
  logic [7:0]    overrun_count;

  generation_scheduler #(.TICK_DIVIDER(TD), .COUNT_WIDTH(CW)) dut (
    .clock(clock), .reset_n(reset_n), .run(run), .speed(speed), .step(step),
    .clear(clear), .edit_hold(edit_hold), .step_req(step_req), .step_done(step_done),
    .clear_req(clear_req), .clear_done(clear_done), .busy(busy),
    .generation_count(generation_count), .overrun_count(overrun_count)
  );

  always #5 clock = ~clock;

  // Model: phase within current period, latched speed, mode 0=idle 1=step 2=clear
  int unsigned m_phase, m_spd, m_mode, m_age, m_gen, m_ovr;
  bit          m_pend, m_clat, m_pstep, m_pclr;
  int unsigned done_dly;
  bit          stray;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_spd = 0; m_mode = 0; m_age = 0; m_gen = 0; m_ovr = 0;
    m_pend = 0; m_clat = 0; m_pstep = 0; m_pclr = 0;
  endtask

  task automatic model_step();
    int unsigned per, prev;
    bit tk, se, ce, issue, enter_c, cdone;
    se      = step && !m_pstep;
    ce      = clear && !m_pclr;
    per     = (m_phase == 0) ? (TD << speed) : (TD << m_spd);
    tk      = run && (m_phase == per - 1);
    if (m_phase == 0) m_spd = speed;
    m_phase = (!run || tk) ? 0 : m_phase + 1;
    issue   = (m_mode == 0) && !m_clat && m_pend && !edit_hold;
    enter_c = (m_mode == 0) && m_clat && !edit_hold;
    cdone   = (m_mode == 2) && clear_done;
    if (cdone) m_ovr = 0;
    else if (tk && m_pend && m_ovr < 255) m_ovr++;
    if (ce || cdone || issue) m_pend = 0;
    else if (tk || (se && !run)) m_pend = 1;
    m_clat = ce || (m_clat && !enter_c);
    prev = m_mode;
    if (enter_c) m_mode = 2;
    else if (issue) m_mode = 1;
    else if (m_mode == 1 && step_done) begin m_mode = 0; m_gen = (m_gen + 1) % (1 << CW); end
    else if (m_mode == 2 && clear_done) begin m_mode = 0; m_gen = 0; end
    m_age   = (m_mode != prev) ? 0 : m_age + 1;
    m_pstep = step;
    m_pclr  = clear;
  endtask

  task automatic check_outs(input string tag);
    chk({tag, "_step_req"}, 32'(step_req), 32'(m_mode == 1));
    chk({tag, "_clear_req"}, 32'(clear_req), 32'(m_mode == 2));
    chk({tag, "_busy"}, 32'(busy), 32'(m_mode != 0));
    chk({tag, "_count"}, 32'(generation_count), m_gen);
`ifdef OVERRUN_COUNTER_EN
    chk({tag, "_overrun"}, 32'(overrun_count), m_ovr);
`else
    chk({tag, "_overrun"}, 32'(overrun_count), 32'd0);
`endif
  endtask

  // One clock: life_game responder, model update, then sample after the edge
  task automatic cyc(input string tag);
    step_done  = ((m_mode == 1) && (m_age >= done_dly)) || (stray && $urandom_range(0, 15) == 0);
    clear_done = ((m_mode == 2) && (m_age >= done_dly)) || (stray && $urandom_range(0, 15) == 0);
    model_step();
    @(posedge clock);
    #1;
    check_outs(tag);
  endtask

  task automatic do_reset(input string tag);
    reset_n = 1'b0;
    model_reset();
    #1;
    check_outs(tag);
    chk({tag, "_req_low"}, 32'(step_req), 32'd0);
    chk({tag, "_count_zero"}, 32'(generation_count), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    int unsigned g0;
    reset_n = 1'b1; run = 1'b0; speed = 2'd0; step = 1'b0; clear = 1'b0;
    edit_hold = 1'b0; step_done = 1'b0; clear_done = 1'b0;
    done_dly = 1; stray = 1'b0;
    model_reset();
    do_reset("reset");

    // Auto-run at base period
    run = 1'b1;
    repeat (17) cyc("t1");

    // Speed change mid-period applies from the next period
    repeat (2) cyc("t2");
    speed = 2'd3;
    repeat (70) cyc("t2");

    // Paused: a held step button yields exactly one step
    run = 1'b0; speed = 2'd0;
    repeat (8) cyc("t3_drain");
    g0 = m_gen;
    step = 1'b1;
    repeat (10) cyc("t3");
    step = 1'b0;
    repeat (6) cyc("t3");
    chk("t3_one_step", 32'(generation_count), (g0 + 1) % (1 << CW));

    // Slow life_game while running: lost ticks
    run = 1'b1; done_dly = 20;
    repeat (60) cyc("t4");
    done_dly = 1; run = 1'b0;
    repeat (8) cyc("t4_drain");

    // Clear arriving during a step: step completes first, then clear
    clear = 1'b1; cyc("t5"); clear = 1'b0;
    repeat (5) cyc("t5");
    chk("t5_cleared", 32'(generation_count), 32'd0);
    repeat (5) begin
      step = 1'b1; cyc("t5"); step = 1'b0;
      repeat (5) cyc("t5");
    end
    chk("t5_count5", 32'(generation_count), 32'd5);
    done_dly = 6;
    step = 1'b1; cyc("t5"); step = 1'b0;
    repeat (2) cyc("t5");
    clear = 1'b1; cyc("t5"); clear = 1'b0;
    repeat (15) cyc("t5");
    chk("t5_final_zero", 32'(generation_count), 32'd0);
    done_dly = 1;

    // Edit hold blocks issue; release issues next cycle; reset mid-request
    edit_hold = 1'b1; run = 1'b1;
    repeat (12) cyc("t6");
    edit_hold = 1'b0;
    done_dly = 50;
    cyc("t6");
    chk("t6_release_req", 32'(step_req), 32'd1);
    repeat (3) cyc("t6");
    do_reset("t6_reset");
    done_dly = 1; run = 1'b0;

    // Randomized traffic including stray done pulses and occasional resets
    stray = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 63) == 0) run = ~run;
      if ($urandom_range(0, 31) == 0) speed = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) step = ~step;
      if ($urandom_range(0, 59) == 0) clear = ~clear;
      if ($urandom_range(0, 19) == 0) edit_hold = ~edit_hold;
      if ($urandom_range(0, 29) == 0) done_dly = $urandom_range(0, 6);
      if ($urandom_range(0, 799) == 0) do_reset("rnd_reset");
      cyc("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
